stage4_memory: RTL
==================

STAGE4_MEMORY -- requirements
Module: stage4_memory

Interface
REQ-001 Parameter REGISTER_WIDTH, default 32 (from common), datapath/address width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low (asserted at 0).
REQ-004 axis_execute_to_memory  Axis.in  struct  from execute; tdata carries decoded_instruction, rs1_value, rs2_value, alu_result, branch_taken, branch_target.
REQ-005 axis_memory_to_writeback  Axis.out  struct  to writeback; tdata carries decoded_instruction, alu_result, load_data, branch_taken, branch_target, misaligned.
REQ-006 dmem_req_valid  output  1  data-memory request valid.
REQ-007 dmem_req_ready  input  1  memory accepts request this cycle.
REQ-008 dmem_req_write  output  1  1 = store, 0 = load.
REQ-009 dmem_req_addr  output  REGISTER_WIDTH  word-aligned byte address (bits [1:0] = 0).
REQ-010 dmem_req_wdata  output  REGISTER_WIDTH  lane-aligned store data.
REQ-011 dmem_req_wstrb  output  4  byte-lane enables.
REQ-012 dmem_rsp_valid  input  1  load data valid (one pulse per load request; none for stores).
REQ-013 dmem_rsp_rdata  input  REGISTER_WIDTH  full word read data.

Function
REQ-014 FSM states: IDLE, REQUEST, WAIT_RSP, HOLD; reset state IDLE.
REQ-015 IDLE: input tready = 1 when the output register is empty or drains this cycle; otherwise 0.
REQ-016 Input accepted on tvalid && tready; accepted transaction captured into an internal register.
REQ-017 Effective address = rs1_value + sign-extended immediate (i_type for OPCODE_LOAD, s_type for OPCODE_STORE), modulo 2^REGISTER_WIDTH.
REQ-018 Non-memory opcodes: bypass memory; output tvalid asserted the cycle after acceptance (1-cycle latency); state stays IDLE.
REQ-019 Load/store, aligned: IDLE -> REQUEST on acceptance; dmem_req_valid = 1 only in REQUEST.
REQ-020 REQUEST, dmem_req_ready = 0: request fields held stable, state unchanged.
REQ-021 REQUEST, ready = 1, store: -> HOLD, output tvalid next cycle; ready = 1, load: -> WAIT_RSP.
REQ-022 WAIT_RSP: on dmem_rsp_valid, capture extracted load_data, -> HOLD; responses arriving in any other state are ignored.
REQ-023 HOLD: output tvalid = 1; on tready -> IDLE; a new input may be accepted in the same cycle (back-to-back).
REQ-024 Input tready = 0 in REQUEST, WAIT_RSP, and HOLD without downstream tready.
REQ-025 Alignment: LW/SW need addr[1:0] = 0; LH/LHU/SH need addr[0] = 0; byte accesses are always aligned.
REQ-026 Misaligned access: no memory request; misaligned = 1; forwarded with bypass latency; load_data = 0.
REQ-027 Store lanes: SB wstrb = 1 << addr[1:0], data byte replicated across all lanes; SH wstrb = 0011 or 1100 by addr[1], half replicated; SW wstrb = 1111.
REQ-028 Load extraction by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
REQ-029 decoded_instruction, alu_result, branch_taken and branch_target pass unchanged.
REQ-030 Output tdata stable while tvalid = 1 and tready = 0.

Reset
REQ-031 rst = 0 forces state IDLE, output tvalid 0, dmem_req_valid 0 and all captured data 0, immediately and independent of clk.
REQ-032 Reset mid-transaction (REQUEST/WAIT_RSP) abandons the access; a later stale dmem_rsp_valid is ignored.
REQ-033 Input tready = 0 while rst = 0; first acceptance is possible on the first rising edge after release.

Verification
REQ-034 LW with rs1=0x100, imm=4, memory returns 0xDEADBEEF one cycle after accept -> addr 0x104, wstrb 0000, write 0, load_data 0xDEADBEEF.
REQ-035 LB with rs1=0x203, imm=0, rdata 0x80FF_FFFF -> addr 0x200, load_data 0xFFFFFF80; same access as LBU -> 0x00000080.
REQ-036 SH with rs1=0x302, imm=0, rs2=0x1234ABCD -> addr 0x300, wstrb 1100, wdata 0xABCDABCD, output tvalid one cycle after ready.
REQ-037 dmem_req_ready held 0 for 5 cycles during SW -> dmem_req_valid and fields stable for 5 cycles, input tready 0 throughout.
REQ-038 LW with addr 0x101 -> no dmem_req_valid, misaligned=1, output the next cycle.
REQ-039 Reset asserted in WAIT_RSP, then dmem_rsp_valid after release -> no output transaction, state IDLE.

Source files
------------

// File: rtl/stage4_memory_if.sv
// Bundles the execute->memory stream, memory->writeback stream and data-memory bus of stage 4.
// The master modport is the memory stage itself; slave is its surroundings.
interface stage4_memory_if #(
  parameter int REGISTER_WIDTH = 32
);
  // execute -> memory stream
  logic                      ex_tvalid;
  logic                      ex_tready;
  logic [31:0]               ex_decoded_instruction;
  logic [REGISTER_WIDTH-1:0] ex_rs1_value;
  logic [REGISTER_WIDTH-1:0] ex_rs2_value;
  logic [REGISTER_WIDTH-1:0] ex_alu_result;
  logic                      ex_branch_taken;
  logic [REGISTER_WIDTH-1:0] ex_branch_target;

  // memory -> writeback stream
  logic                      wb_tvalid;
  logic                      wb_tready;
  logic [31:0]               wb_decoded_instruction;
  logic [REGISTER_WIDTH-1:0] wb_alu_result;
  logic [REGISTER_WIDTH-1:0] wb_load_data;
  logic                      wb_branch_taken;
  logic [REGISTER_WIDTH-1:0] wb_branch_target;
  logic                      wb_misaligned;

  // data memory
  logic                      dmem_req_valid;
  logic                      dmem_req_ready;
  logic                      dmem_req_write;
  logic [REGISTER_WIDTH-1:0] dmem_req_addr;
  logic [REGISTER_WIDTH-1:0] dmem_req_wdata;
  logic [3:0]                dmem_req_wstrb;
  logic                      dmem_rsp_valid;
  logic [REGISTER_WIDTH-1:0] dmem_rsp_rdata;

  modport master (
    input  ex_tvalid, ex_decoded_instruction, ex_rs1_value, ex_rs2_value,
           ex_alu_result, ex_branch_taken, ex_branch_target,
    output ex_tready,
    output wb_tvalid, wb_decoded_instruction, wb_alu_result, wb_load_data,
           wb_branch_taken, wb_branch_target, wb_misaligned,
    input  wb_tready,
    output dmem_req_valid, dmem_req_write, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );

  modport slave (
    output ex_tvalid, ex_decoded_instruction, ex_rs1_value, ex_rs2_value,
           ex_alu_result, ex_branch_taken, ex_branch_target,
    input  ex_tready,
    input  wb_tvalid, wb_decoded_instruction, wb_alu_result, wb_load_data,
           wb_branch_taken, wb_branch_target, wb_misaligned,
    output wb_tready,
    input  dmem_req_valid, dmem_req_write, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
    output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );
endinterface

// File: rtl/stage4_memory.sv
// Pipeline stage 4: issues loads/stores to data memory, bypasses everything else.
// decoded_instruction is the raw RV32 instruction word; opcode/funct3/immediates are sliced from it.
module stage4_memory #(
  parameter int REGISTER_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  stage4_memory_if.master   bus
);
  localparam int W = REGISTER_WIDTH;
  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT_RSP, HOLD} state_t;
  state_t state_reg, state_next;

  logic         ex_is_load, ex_is_store, ex_misaligned, ex_mem_op;
  logic [1:0]   ex_size;
  logic [W-1:0] ex_imm, ex_addr, ex_wdata;
  logic [3:0]   ex_wstrb;

  logic [31:0]  instr_reg;
  logic [W-1:0] alu_reg, target_reg, addr_reg, wdata_reg, load_data_reg;
  logic [3:0]   wstrb_reg;
  logic         taken_reg, write_reg, misaligned_reg, wb_valid_reg;

  logic         ex_ready, accept, wb_valid_next, load_capture;
  logic [W-1:0] rsp_shifted, load_value;

  assign ex_is_load  = bus.ex_decoded_instruction[6:0] == OPCODE_LOAD;
  assign ex_is_store = bus.ex_decoded_instruction[6:0] == OPCODE_STORE;
  assign ex_size     = bus.ex_decoded_instruction[13:12];

  always_comb begin
    if (ex_is_store)
      ex_imm = {{(W-12){bus.ex_decoded_instruction[31]}},
                bus.ex_decoded_instruction[31:25], bus.ex_decoded_instruction[11:7]};
    else
      ex_imm = {{(W-12){bus.ex_decoded_instruction[31]}}, bus.ex_decoded_instruction[31:20]};
  end

  assign ex_addr       = bus.ex_rs1_value + ex_imm;
  assign ex_misaligned = (ex_is_load || ex_is_store) &&
                         ((ex_size[1] && ex_addr[1:0] != 2'b00) ||
                          (ex_size == 2'b01 && ex_addr[0]));
  assign ex_mem_op     = (ex_is_load || ex_is_store) && !ex_misaligned;

  always_comb begin
    ex_wstrb = 4'b0000;
    if (ex_is_store) begin
      case (ex_size)
        2'b00:   ex_wstrb = 4'b0001 << ex_addr[1:0];
        2'b01:   ex_wstrb = ex_addr[1] ? 4'b1100 : 4'b0011;
        default: ex_wstrb = 4'b1111;
      endcase
    end
  end

  // Each byte lane carries the byte/half replicated, or its own byte for a word store.
  for (genvar gi = 0; gi < W/8; gi++) begin : g_lane
    assign ex_wdata[gi*8 +: 8] = !ex_is_store      ? 8'h00 :
                                 ex_size == 2'b00  ? bus.ex_rs2_value[7:0] :
                                 ex_size == 2'b01  ? bus.ex_rs2_value[(gi%2)*8 +: 8] :
                                                     bus.ex_rs2_value[gi*8 +: 8];
  end

  assign rsp_shifted = bus.dmem_rsp_rdata >> {addr_reg[1:0], 3'b000};

  always_comb begin
    case (instr_reg[14:12])
      3'b000:  load_value = {{(W-8){rsp_shifted[7]}}, rsp_shifted[7:0]};
      3'b001:  load_value = {{(W-16){rsp_shifted[15]}}, rsp_shifted[15:0]};
      3'b100:  load_value = {{(W-8){1'b0}}, rsp_shifted[7:0]};
      3'b101:  load_value = {{(W-16){1'b0}}, rsp_shifted[15:0]};
      default: load_value = rsp_shifted;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    ex_ready      = 1'b0;
    accept        = 1'b0;
    wb_valid_next = wb_valid_reg;
    load_capture  = 1'b0;
    case (state_reg)
      IDLE, HOLD: begin
        // The output register frees up when empty or when it drains this cycle.
        ex_ready = rst && (!wb_valid_reg || bus.wb_tready);
        if (bus.wb_tready) begin
          wb_valid_next = 1'b0;
          state_next    = IDLE;
        end
        accept = bus.ex_tvalid && ex_ready;
        if (accept) begin
          if (ex_mem_op) state_next    = REQUEST;
          else           wb_valid_next = 1'b1;
        end
      end
      REQUEST: begin
        if (bus.dmem_req_ready) begin
          if (write_reg) begin
            state_next    = HOLD;
            wb_valid_next = 1'b1;
          end else begin
            state_next = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        if (bus.dmem_rsp_valid) begin
          load_capture  = 1'b1;
          state_next    = HOLD;
          wb_valid_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      wb_valid_reg   <= 1'b0;
      instr_reg      <= '0;
      alu_reg        <= '0;
      target_reg     <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      wstrb_reg      <= '0;
      load_data_reg  <= '0;
      taken_reg      <= 1'b0;
      write_reg      <= 1'b0;
      misaligned_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wb_valid_reg <= wb_valid_next;
      if (accept) begin
        instr_reg      <= bus.ex_decoded_instruction;
        alu_reg        <= bus.ex_alu_result;
        target_reg     <= bus.ex_branch_target;
        taken_reg      <= bus.ex_branch_taken;
        addr_reg       <= ex_addr;
        wdata_reg      <= ex_wdata;
        wstrb_reg      <= ex_wstrb;
        write_reg      <= ex_is_store;
        misaligned_reg <= ex_misaligned;
        load_data_reg  <= '0;
      end
      if (load_capture) load_data_reg <= load_value;
    end
  end

  assign bus.ex_tready              = ex_ready;
  assign bus.wb_tvalid              = wb_valid_reg;
  assign bus.wb_decoded_instruction = instr_reg;
  assign bus.wb_alu_result          = alu_reg;
  assign bus.wb_load_data           = load_data_reg;
  assign bus.wb_branch_taken        = taken_reg;
  assign bus.wb_branch_target       = target_reg;
  assign bus.wb_misaligned          = misaligned_reg;

  assign bus.dmem_req_valid = state_reg == REQUEST;
  assign bus.dmem_req_write = write_reg;
  assign bus.dmem_req_addr  = {addr_reg[W-1:2], 2'b00};
  assign bus.dmem_req_wdata = wdata_reg;
  assign bus.dmem_req_wstrb = wstrb_reg;
endmodule
